// File: rtl/mem_request_arbiter.sv
// Shares one single-ported RAM between the fetch and load/store paths.
// One access at a time, registered RAM strobes, timeout on a hung RAM.
module mem_request_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        imem_ren,
   input  logic [31:0] imem_addr,
   input  logic        dmem_ren,
   input  logic        dmem_wen,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_store,
   input  logic        ram_ready,
   input  logic [31:0] ram_load,
   output logic        ram_ren,
   output logic        ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_store,
   output logic [31:0] imem_load,
   output logic [31:0] dmem_load,
   output logic        i_ready,
   output logic        d_ready,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      INSTR,
      RESP
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_grant;
   logic          is_wr;

   logic dreq;
   logic ireq;
   logic gnt_d;
   logic expired;

   assign dreq    = dmem_ren | dmem_wen;
   assign ireq    = imem_ren;
   // Data wins a tie unless it also won the previous grant.
   assign gnt_d   = dreq & (~ireq | ~last_grant);
   assign expired = ~ram_ready & (cnt == CMAX);

   // Arbitration, access sequencing and response pulse.
   always_ff @(posedge clk) begin
      if (!nRST) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b0;
         is_wr      <= 1'b0;
         ram_ren    <= 1'b0;
         ram_wen    <= 1'b0;
         ram_addr   <= '0;
         ram_store  <= '0;
         imem_load  <= '0;
         dmem_load  <= '0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dreq | ireq) begin
                  cnt        <= '0;
                  last_grant <= gnt_d;
                  if (gnt_d) begin
                     ram_addr  <= dmem_addr;
                     ram_store <= dmem_store;
                     ram_wen   <= dmem_wen;
                     ram_ren   <= ~dmem_wen;
                     is_wr     <= dmem_wen;
                     state     <= DATA;
                  end else begin
                     ram_addr <= imem_addr;
                     ram_ren  <= 1'b1;
                     ram_wen  <= 1'b0;
                     is_wr    <= 1'b0;
                     state    <= INSTR;
                  end
               end
            end
            DATA, INSTR: begin
               if (ram_ready | expired) begin
                  ram_ren <= 1'b0;
                  ram_wen <= 1'b0;
                  bus_err <= expired;
                  i_ready <= (state == INSTR);
                  d_ready <= (state == DATA);
                  if (state == INSTR)
                     imem_load <= ram_ready ? ram_load : ERR_WORD;
                  else if (!is_wr)
                     dmem_load <= ram_ready ? ram_load : ERR_WORD;
                  state <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               bus_err <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: vector table plus
// hand-written contention, timeout and mid-access reset sequences.
module tb_mem_request_arbiter;

   logic        clk = 1'b0;
   logic        nRST;
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        dmem_ren;
   logic        dmem_wen;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_store;
   logic        ram_ready;
   logic [31:0] ram_load;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_store;
   logic [31:0] imem_load;
   logic [31:0] dmem_load;
   logic        i_ready;
   logic        d_ready;
   logic        bus_err;

   int ntests = 0;
   int nfail  = 0;

   mem_request_arbiter #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .nRST      (nRST),
      .imem_ren  (imem_ren),
      .imem_addr (imem_addr),
      .dmem_ren  (dmem_ren),
      .dmem_wen  (dmem_wen),
      .dmem_addr (dmem_addr),
      .dmem_store(dmem_store),
      .ram_ready (ram_ready),
      .ram_load  (ram_load),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_store (ram_store),
      .imem_load (imem_load),
      .dmem_load (dmem_load),
      .i_ready   (i_ready),
      .d_ready   (d_ready),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst_n;
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] ds;
      logic        rr;
      logic [31:0] rl;
   } in_t;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic        ir;
      logic        dr;
      logic        be;
      logic [31:0] il;
      logic [31:0] dl;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t e;
   } vec_t;

   vec_t tbl[20];

   function automatic in_t mi(logic r, logic ir, logic [31:0] ia,
                              logic dr, logic dw, logic [31:0] da,
                              logic [31:0] ds, logic rr,
                              logic [31:0] rl);
      in_t x;
      x = '{r, ir, ia, dr, dw, da, ds, rr, rl};
      return x;
   endfunction

   function automatic out_t mo(logic ren, logic wen, logic [31:0] a,
                               logic [31:0] s, logic ir, logic dr,
                               logic be, logic [31:0] il,
                               logic [31:0] dl);
      out_t x;
      x = '{ren, wen, a, s, ir, dr, be, il, dl};
      return x;
   endfunction

   task automatic drive(input in_t v);
      nRST       = v.rst_n;
      imem_ren   = v.ir;
      imem_addr  = v.ia;
      dmem_ren   = v.dr;
      dmem_wen   = v.dw;
      dmem_addr  = v.da;
      dmem_store = v.ds;
      ram_ready  = v.rr;
      ram_load   = v.rl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic out_t snap();
      out_t x;
      x = '{ram_ren, ram_wen, ram_addr, ram_store, i_ready, d_ready,
            bus_err, imem_load, dmem_load};
      return x;
   endfunction

   localparam logic [31:0] I0 = 32'h0050_0093;
   localparam logic [31:0] W0 = 32'h1234_5678;
   localparam logic [31:0] R0 = 32'hCAFE_F00D;
   localparam logic [31:0] S5 = 32'hA5A5_A5A5;

   initial begin
      out_t got;
      logic [31:0] grants[$];
      logic [31:0] lastg;
      logic        prev;
      int          n;

      drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));

      tbl[0]  = '{mi(0,1,32'h10,1,0,32'h100,0,0,0),
                  mo(0,0,0,0,0,0,0,0,0)};
      tbl[1]  = '{mi(0,1,32'h10,1,0,32'h100,0,1,0),
                  mo(0,0,0,0,0,0,0,0,0)};
      tbl[2]  = '{mi(1,0,0,0,0,0,0,0,0),
                  mo(0,0,0,0,0,0,0,0,0)};
      tbl[3]  = '{mi(1,0,0,0,0,0,0,0,0),
                  mo(0,0,0,0,0,0,0,0,0)};
      tbl[4]  = '{mi(1,1,32'h10,0,0,0,0,0,0),
                  mo(1,0,32'h10,0,0,0,0,0,0)};
      tbl[5]  = '{mi(1,1,32'h10,0,0,0,0,1,I0),
                  mo(0,0,32'h10,0,1,0,0,I0,0)};
      tbl[6]  = '{mi(1,0,0,0,0,0,0,0,0),
                  mo(0,0,32'h10,0,0,0,0,I0,0)};
      tbl[7]  = '{mi(1,0,0,0,1,32'h100,W0,0,0),
                  mo(0,1,32'h100,W0,0,0,0,I0,0)};
      tbl[8]  = '{mi(1,0,0,0,1,32'h100,W0,0,0),
                  mo(0,1,32'h100,W0,0,0,0,I0,0)};
      tbl[9]  = '{mi(1,1,32'h8,0,1,32'h200,0,0,0),
                  mo(0,1,32'h100,W0,0,0,0,I0,0)};
      tbl[10] = '{mi(1,0,0,0,1,32'h100,W0,0,0),
                  mo(0,1,32'h100,W0,0,0,0,I0,0)};
      tbl[11] = '{mi(1,0,0,0,1,32'h100,W0,1,32'hFFFF_FFFF),
                  mo(0,0,32'h100,W0,0,1,0,I0,0)};
      tbl[12] = '{mi(1,0,0,0,0,0,0,0,0),
                  mo(0,0,32'h100,W0,0,0,0,I0,0)};
      tbl[13] = '{mi(1,0,0,1,0,32'h44,0,0,0),
                  mo(1,0,32'h44,0,0,0,0,I0,0)};
      tbl[14] = '{mi(1,0,0,1,0,32'h44,0,1,R0),
                  mo(0,0,32'h44,0,0,1,0,I0,R0)};
      tbl[15] = '{mi(1,0,0,0,0,0,0,0,0),
                  mo(0,0,32'h44,0,0,0,0,I0,R0)};
      tbl[16] = '{mi(1,0,0,1,1,32'h80,S5,0,0),
                  mo(0,1,32'h80,S5,0,0,0,I0,R0)};
      tbl[17] = '{mi(1,0,0,1,1,32'h80,S5,1,32'h1111_1111),
                  mo(0,0,32'h80,S5,0,1,0,I0,R0)};
      tbl[18] = '{mi(1,0,0,0,0,0,0,1,32'h2222_2222),
                  mo(0,0,32'h80,S5,0,0,0,I0,R0)};
      tbl[19] = '{mi(1,0,0,0,0,0,0,1,32'h3333_3333),
                  mo(0,0,32'h80,S5,0,0,0,I0,R0)};

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(tbl[k].i);
         tick();
         got = snap();
         ntests++;
         if (got !== tbl[k].e) begin
            nfail++;
            $display("FAIL vec%0d: got %h expected %h",
                     k, got, tbl[k].e);
         end
      end

      // Contention from reset with a zero-wait RAM model.
      @(negedge clk);
      drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      @(negedge clk);
      drive(mi(1, 1, 32'h1000, 1, 0, 32'h2000, 0, 0, 0));
      prev  = 1'b0;
      lastg = '0;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) begin
            @(negedge clk);
            ram_ready = ram_ren | ram_wen;
            ram_load  = ram_addr ^ 32'h5A5A_0000;
         end
         tick();
         if ((ram_ren | ram_wen) && !prev) begin
            grants.push_back(ram_addr);
            lastg = ram_addr;
         end
         prev = ram_ren | ram_wen;
         if (i_ready) begin
            chk("cont_i_owner", 64'(lastg), 64'(32'h1000));
            chk("cont_i_load", 64'(imem_load),
                64'(32'h5A5A_1000));
         end
         if (d_ready) begin
            chk("cont_d_owner", 64'(lastg), 64'(32'h2000));
            chk("cont_d_load", 64'(dmem_load),
                64'(32'h5A5A_2000));
         end
         if (i_ready && d_ready)
            chk("cont_both_rdy", 64'(1), 64'(0));
      end
      chk("cont_ngrant", 64'(grants.size() >= 4), 64'(1));
      if (grants.size() >= 4) begin
         chk("cont_g0", 64'(grants[0]), 64'(32'h2000));
         chk("cont_g1", 64'(grants[1]), 64'(32'h1000));
         chk("cont_g2", 64'(grants[2]), 64'(32'h2000));
         chk("cont_g3", 64'(grants[3]), 64'(32'h1000));
      end

      // Timeout on a data read with a dead RAM.
      @(negedge clk);
      drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      @(negedge clk);
      drive(mi(1, 0, 0, 1, 0, 32'h300, 0, 0, 0));
      tick();
      chk("to_strobe", 64'(ram_ren), 64'(1));
      n = 0;
      while (ram_ren === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("to_cycles", 64'(n), 64'(16));
      chk("to_dready", 64'(d_ready), 64'(1));
      chk("to_buserr", 64'(bus_err), 64'(1));
      chk("to_iready", 64'(i_ready), 64'(0));
      chk("to_dload", 64'(dmem_load), 64'(32'hDEAD_BEEF));
      @(negedge clk);
      dmem_ren = 1'b0;
      tick();
      chk("to_drop", 64'({d_ready, bus_err}), 64'(0));

      // Reset in the middle of a fetch wait, then a clean retry.
      @(negedge clk);
      drive(mi(1, 1, 32'h40, 0, 0, 0, 0, 0, 0));
      tick();
      chk("mr_grant", 64'({ram_ren, ram_addr}), {31'd0, 1'b1, 32'h40});
      @(negedge clk);
      nRST = 1'b0;
      tick();
      chk("mr_abort", 64'({ram_ren, i_ready, bus_err}), 64'(0));
      chk("mr_iload", 64'(imem_load), 64'(0));
      @(negedge clk);
      nRST = 1'b1;
      tick();
      chk("mr_regrant", 64'({ram_ren, i_ready}), 64'(2'b10));
      @(negedge clk);
      ram_ready = 1'b1;
      ram_load  = 32'h0000_0013;
      tick();
      chk("mr_done", 64'({ram_ren, i_ready, bus_err}), 64'(3'b010));
      chk("mr_load", 64'(imem_load), 64'(32'h13));
      @(negedge clk);
      drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      chk("mr_idle", 64'({ram_ren, i_ready}), 64'(0));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Sequences and shares one single-ported RAM between the instruction-fetch requester (PC/fetch path) and the data-memory requester (load/store path).
- Latches one request at a time and drives the RAM interface from registers.
- Returns read data, then pulses the requester's ready signal. The PC holds on i_ready and the writeback path holds on d_ready.
- A wait-state timeout guarantees forward progress against a hung RAM.

Parameters:
- TIMEOUT, 16, max cycles spent in an access state without ram_ready before the access is aborted (must be ≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- nRST  in  1  synchronous active-low reset, sampled on rising clk
- imem_ren  in  1  instruction fetch request; held until i_ready
- imem_addr  in  32  fetch address
- dmem_ren  in  1  data read request; held until d_ready
- dmem_wen  in  1  data write request; held until d_ready
- dmem_addr  in  32  data address
- dmem_store  in  32  data write value
- ram_ready  in  1  RAM completes the current access this cycle
- ram_load  in  32  RAM read data, valid when ram_ready=1
- ram_ren  out  1  RAM read strobe, registered
- ram_wen  out  1  RAM write strobe, registered
- ram_addr  out  32  RAM address, registered
- ram_store  out  32  RAM write data, registered
- imem_load  out  32  fetched instruction; held until next fetch completes
- dmem_load  out  32  loaded data; held until next data read completes
- i_ready  out  1  one-cycle pulse: fetch complete
- d_ready  out  1  one-cycle pulse: data access complete
- bus_err  out  1  high together with the ready pulse when the access timed out

Behaviour:
- Reset: nRST=0 at a rising edge gives state=IDLE, and all outputs, the counter and last_grant are 0. Reset applies from any state and aborts an in-flight access without a ready pulse.
- FSM states are IDLE, DATA, INSTR and RESP.
- IDLE arbitration:
  - A data request is pending when dmem_ren|dmem_wen. An instruction request is pending when imem_ren.
  - Only one pending: grant it.
  - Both pending: grant data, unless last_grant==DATA, then grant INSTR. This alternates and prevents starvation.
  - last_grant updates on each grant.
- On grant, the request is latched in the same edge into ram_addr, ram_store, ram_ren and ram_wen, and the counter is cleared.
  - A data grant goes to DATA.
  - A fetch grant goes to INSTR with ram_ren=1, ram_wen=0.
- dmem_ren and dmem_wen both high: treat as a write (ram_wen=1, ram_ren=0). dmem_load is not updated.
- DATA/INSTR states:
  - ram_* outputs hold stable.
  - The counter increments each cycle that ram_ready=0.
- Completion, when ram_ready=1:
  - Capture ram_load into dmem_load (DATA read only) or imem_load (INSTR).
  - Clear ram_ren and ram_wen. Go to RESP with bus_err=0.
- Timeout, when ram_ready=0 and counter==TIMEOUT-1:
  - Clear the strobes. Go to RESP with bus_err=1.
  - Load 32'hDEAD_BEEF into the relevant load register. For an aborted write, no load register changes.
- RESP state:
  - For exactly one cycle, pulse i_ready or d_ready matching the finished access, with bus_err valid.
  - Requests are not sampled in RESP. The requester drops or changes its request during this cycle.
  - Next state is IDLE, with bus_err cleared.
- Latency:
  - Request visible in IDLE at cycle 0 → strobe at cycle 1.
  - ram_ready at cycle k≥1 → ready pulse at cycle k+1.
  - Zero-wait RAM gives 2 cycles from request to ready, and 3 cycles between back-to-back grants.
- ram_ready while in IDLE or RESP is ignored.
- Request inputs changing mid-access have no effect; the latched values are used.
- Addresses pass through unmodified (no alignment masking). The counter is wide enough for TIMEOUT.

Test Plan:
- Reset/idle: nRST=0 for 2 cycles with requests asserted → all outputs 0. After release with no requests → ram_ren=ram_wen=0 indefinitely.
- Fetch with zero wait:
  - Stimulus: imem_ren=1, imem_addr=0x0000_0010; RAM returns ram_ready=1 with ram_load=0x0050_0093 the cycle after ram_ren rises.
  - Response: ram_addr=0x10, ram_ren=1 at cycle 1; i_ready pulse at cycle 2 with imem_load=0x0050_0093, bus_err=0.
- Data write with waits: dmem_wen=1, addr 0x0000_0100, store 0x1234_5678, ram_ready delayed 3 cycles → ram_wen held for 4 cycles with stable addr/data; d_ready pulse 1 cycle later; dmem_load unchanged.
- Contention:
  - Stimulus: imem_ren and dmem_ren held together from reset.
  - Response: grants in order DATA, INSTR, DATA, INSTR; each ready pulses only for its own access.
- Timeout: dmem_ren=1 with ram_ready tied 0 and TIMEOUT=16 → strobe drops after 16 access cycles; d_ready=1 and bus_err=1 for one cycle; dmem_load=0xDEAD_BEEF.
- Mid-access reset: assert nRST=0 during INSTR wait → next cycle IDLE with ram_ren=0 and no i_ready pulse. After release, a re-issued fetch completes normally.
